fifo_rd_serializer: RTL and testbench



---
 rtl/fifo_rd_serializer.sv | 212 +++++++++++++++++++++
 tb/tb_fifo_rd_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer
//   Drains a first-word-fall-through FIFO and sends each popped word as a
//   framed, LSB-first serial stream on a line that idles high. A frame is:
//     start bit (0), DATA_W data bits, [even-parity bit], stop bit (1).
//   Each bit is held for BIT_CYCLES clocks. After the stop bit the line stays
//   high for IDLE_GAP more clocks before the next pop is allowed.
//
//   Optional build macro: FIFO_RD_SER_PARITY_EN
//     defined   -> one even-parity bit (XOR of the data) is sent before the stop bit
//     undefined -> no parity bit; DATA goes straight to STOP
//
// Parameters
//   DATA_W     FIFO word width / serial data field width (>= 2)
//   BIT_CYCLES clocks per serial bit (>= 1)
//   IDLE_GAP   extra idle-high clocks after each stop bit (>= 0)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   enable_i     allows new frames to start
//   empty_i      FIFO empty flag
//   pop_data_i   FIFO head word (valid while empty_i = 0)
//   pop_o        FIFO pop strobe (combinational, IDLE only)
//   ser_o        serial line, idles high (registered)
//   frame_o      high during start/data/parity/stop bits (registered)
//   busy_o       high outside IDLE (registered)
//   frame_done_o one-clock pulse in the last clock of the stop bit (registered)
//   byte_cnt_o   completed-frame count, wraps at 16 bits
module fifo_rd_serializer #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int IDLE_GAP   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] pop_data_i,
    output logic              pop_o,
    output logic              ser_o,
    output logic              frame_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [15:0]       byte_cnt_o
);

    localparam int MAX_CYC = (BIT_CYCLES > IDLE_GAP) ? BIT_CYCLES : IDLE_GAP;
    localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] BIT_PRE   = CYC_W'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
    localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_RD_SER_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_t;

    state_t             state;
    logic [CYC_W-1:0]   cyc;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
`ifdef FIFO_RD_SER_PARITY_EN
    logic               parity;
`endif

    logic bit_end;
    logic enter_stop;
    logic done_next;

    // Gated by reset so the strobe is low while reset is held.
    assign pop_o = reset & enable_i & ~empty_i & (state == IDLE);

    // frame_done_o is registered, so it must be set on the edge that enters
    // the final stop clock: the STOP entry edge when a bit is one clock long,
    // otherwise the edge after the second-to-last stop clock.
    always_comb begin
        bit_end    = (cyc == BIT_LAST);
        enter_stop = 1'b0;
`ifdef FIFO_RD_SER_PARITY_EN
        enter_stop = (state == PARITY) && bit_end;
`else
        enter_stop = (state == DATA) && bit_end && (bit_cnt == DATA_LAST);
`endif
        if (BIT_CYCLES == 1) begin
            done_next = enter_stop;
        end else begin
            done_next = (state == STOP) && (cyc == BIT_PRE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cyc          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
`ifdef FIFO_RD_SER_PARITY_EN
            parity       <= 1'b0;
`endif
            ser_o        <= 1'b1;
            frame_o      <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            byte_cnt_o   <= '0;
        end else begin
            frame_done_o <= done_next;
            if (done_next) begin
                byte_cnt_o <= byte_cnt_o + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (pop_o) begin
                        shreg   <= pop_data_i;
`ifdef FIFO_RD_SER_PARITY_EN
                        parity  <= ^pop_data_i;
`endif
                        cyc     <= '0;
                        state   <= START;
                        ser_o   <= 1'b0;
                        frame_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        ser_o   <= shreg[0];
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bit_cnt == DATA_LAST) begin
`ifdef FIFO_RD_SER_PARITY_EN
                            state <= PARITY;
                            ser_o <= parity;
`else
                            state <= STOP;
                            ser_o <= 1'b1;
`endif
                        end else begin
                            // Next bit is shreg[1] before the shift lands.
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            ser_o   <= shreg[1];
                        end
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end

`ifdef FIFO_RD_SER_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cyc   <= '0;
                        state <= STOP;
                        ser_o <= 1'b1;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        frame_o <= 1'b0;
                        if (IDLE_GAP > 0) begin
                            state <= GAP;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end

                GAP: begin
                    if (cyc == GAP_LAST) begin
                        cyc    <= '0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
module tb_fifo_rd_serializer;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int GAPC = 1;
`ifdef FIFO_RD_SER_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int NS = NB * BC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable_i = 1'b0;
    logic          empty_i = 1'b1;
    logic [DW-1:0] pop_data_i = '0;
    logic          pop_o, ser_o, frame_o, busy_o, frame_done_o;
    logic [15:0]   byte_cnt_o;

    int cmp = 0;
    int err = 0;
    logic [15:0] exp_cnt = '0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] exp_q[$];

    fifo_rd_serializer #(
        .DATA_W(DW),
        .BIT_CYCLES(BC),
        .IDLE_GAP(GAPC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable_i(enable_i),
        .empty_i(empty_i),
        .pop_data_i(pop_data_i),
        .pop_o(pop_o),
        .ser_o(ser_o),
        .frame_o(frame_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .byte_cnt_o(byte_cnt_o)
    );

    always #5 clk = ~clk;

    // FIFO model: pop strobe sampled at negedge, head updated just after posedge.
    initial begin
        logic ps;
        forever begin
            @(negedge clk);
            ps = pop_o;
            @(posedge clk);
            #1;
            if (ps === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
            empty_i    = (fifo.size() == 0);
            pop_data_i = (fifo.size() > 0) ? fifo[0] : '0;
        end
    end

    function automatic logic [NS-1:0] build_wave(input logic [DW-1:0] w);
        logic [NB-1:0] bits;
        logic [NS-1:0] wv;
`ifdef FIFO_RD_SER_PARITY_EN
        bits = {1'b1, ^w, w, 1'b0};
`else
        bits = {1'b1, w, 1'b0};
`endif
        for (int unsigned i = 0; i < NS; i++) wv[i] = bits[i / BC];
        return wv;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        @(posedge clk);
        #1;
        fifo.push_back(w);
        exp_q.push_back(w);
    endtask

    // Waits (bounded) for a pop, then records one frame's worth of samples.
    task automatic recv_frame(output logic [NS-1:0] wave, output logic [NS-1:0] fr,
                              output logic [NS-1:0] dn, output int waited,
                              output bit idle_ok, output int extra_pops, output bit timeout);
        waited = 0; idle_ok = 1'b1; extra_pops = 0; timeout = 1'b0;
        wave = '0; fr = '0; dn = '0;
        forever begin
            @(negedge clk);
            waited++;
            if (ser_o !== 1'b1) idle_ok = 1'b0;
            if (pop_o === 1'b1) break;
            if (waited >= 200) begin timeout = 1'b1; break; end
        end
        if (!timeout) begin
            for (int unsigned i = 0; i < NS; i++) begin
                @(negedge clk);
                wave[i] = ser_o; fr[i] = frame_o; dn[i] = frame_done_o;
                if (pop_o !== 1'b0) extra_pops++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            enable_i = 1'($urandom_range(0, 1));
            fifo.push_back(DW'($urandom));
            @(negedge clk);
            cmp++;
            if ({pop_o, ser_o, busy_o, frame_o, frame_done_o, byte_cnt_o} !== {5'b01000, 16'h0}) begin
                err++;
                $display("FAIL reset_values: got pop=%b ser=%b busy=%b frame=%b done=%b cnt=%h, want 0 1 0 0 0 0000",
                         pop_o, ser_o, busy_o, frame_o, frame_done_o, byte_cnt_o);
            end
        end
        enable_i = 1'b0;
        fifo.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        logic [NS-1:0] wv, fr, dn;
        int waited, extra; bit idle_ok, to;
        logic [DW-1:0] w;
        push_word(8'hAB);
        enable_i = 1'b1;
        recv_frame(wv, fr, dn, waited, idle_ok, extra, to);
        cmp++;
        if (to) begin err++; $display("FAIL single_pop_timeout: no pop seen, want pop"); return; end
        w = exp_q.pop_front();
        exp_cnt++;
        cmp++;
        if (wv !== build_wave(w)) begin err++; $display("FAIL single_wave: got %h want %h", wv, build_wave(w)); end
        cmp++;
        if (fr !== '1) begin err++; $display("FAIL single_frame_o: got %h want all ones", fr); end
        cmp++;
        if (dn !== (NS'(1) << (NS - 1))) begin err++; $display("FAIL single_done: got %h want %h", dn, NS'(1) << (NS - 1)); end
        cmp++;
        if (extra !== 0) begin err++; $display("FAIL single_pop_len: got %0d extra pops want 0", extra); end
        cmp++;
        if (byte_cnt_o !== exp_cnt) begin err++; $display("FAIL single_cnt: got %h want %h", byte_cnt_o, exp_cnt); end
        @(negedge clk);
        cmp++;
        if ({ser_o, frame_o, busy_o, frame_done_o} !== 4'b1010) begin
            err++; $display("FAIL single_post: got ser/frame/busy/done=%b want 1010", {ser_o, frame_o, busy_o, frame_done_o});
        end
    endtask

    task automatic test_empty;
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmp++;
            if ({pop_o, ser_o, busy_o} !== 3'b010) begin
                err++; $display("FAIL empty_idle: got pop/ser/busy=%b want 010", {pop_o, ser_o, busy_o});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [NS-1:0] wv, fr, dn;
        int waited, extra; bit idle_ok, to;
        logic [DW-1:0] w;
        enable_i = 1'b0;
        push_word(8'hAB);
        push_word(8'hCC);
        @(posedge clk);
        #1;
        enable_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            recv_frame(wv, fr, dn, waited, idle_ok, extra, to);
            cmp++;
            if (to) begin err++; $display("FAIL b2b_timeout: frame %0d no pop", k); return; end
            w = exp_q.pop_front();
            exp_cnt++;
            cmp++;
            if (wv !== build_wave(w)) begin err++; $display("FAIL b2b_wave%0d: got %h want %h", k, wv, build_wave(w)); end
            if (k == 1) begin
                cmp++;
                if (waited !== GAPC + 1 || !idle_ok) begin
                    err++; $display("FAIL b2b_gap: got %0d idle clocks (high=%0b) want %0d high", waited, idle_ok, GAPC + 1);
                end
            end
        end
        cmp++;
        if (byte_cnt_o !== exp_cnt) begin err++; $display("FAIL b2b_cnt: got %h want %h", byte_cnt_o, exp_cnt); end
        cmp++;
        if (empty_i !== 1'b1) begin err++; $display("FAIL b2b_empty: got %b want 1", empty_i); end
    endtask

    task automatic test_enable_drop;
        logic [NS-1:0] wv, fr, dn;
        int waited, extra; bit idle_ok, to;
        logic [DW-1:0] w;
        enable_i = 1'b0;
        push_word(8'hAB);
        push_word(8'hCC);
        @(posedge clk);
        #1;
        enable_i = 1'b1;
        fork
            recv_frame(wv, fr, dn, waited, idle_ok, extra, to);
            begin
                repeat (14) @(posedge clk);
                #1;
                enable_i = 1'b0;
            end
        join
        cmp++;
        if (to) begin err++; $display("FAIL drop_timeout: no pop"); return; end
        w = exp_q.pop_front();
        exp_cnt++;
        cmp++;
        if (wv !== build_wave(w)) begin err++; $display("FAIL drop_wave: got %h want %h", wv, build_wave(w)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp++;
            if (pop_o !== 1'b0) begin err++; $display("FAIL drop_no_pop: got pop=%b want 0", pop_o); end
        end
        cmp++;
        if (fifo.size() != 1) begin err++; $display("FAIL drop_fifo: got %0d words want 1", fifo.size()); end
        @(posedge clk);
        #1;
        enable_i = 1'b1;
        recv_frame(wv, fr, dn, waited, idle_ok, extra, to);
        cmp++;
        if (to || waited !== 1) begin err++; $display("FAIL drop_repop: got wait %0d (timeout %0b) want 1", waited, to); end
        if (!to) begin
            w = exp_q.pop_front();
            exp_cnt++;
            cmp++;
            if (wv !== build_wave(w)) begin err++; $display("FAIL drop_wave2: got %h want %h", wv, build_wave(w)); end
            cmp++;
            if (byte_cnt_o !== exp_cnt) begin err++; $display("FAIL drop_cnt: got %h want %h", byte_cnt_o, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [NS-1:0] wv, fr, dn;
        int waited, extra; bit idle_ok, to;
        logic [DW-1:0] w;
        int n;
        repeat (8) @(negedge clk);
        enable_i = 1'b0;
        push_word(8'hAB);
        push_word(8'hCC);
        @(posedge clk);
        #1;
        enable_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (pop_o !== 1'b1 && n < 100);
        cmp++;
        if (pop_o !== 1'b1) begin err++; $display("FAIL rst_mid_pop: got no pop want pop"); return; end
        repeat (18) @(negedge clk);  // inside data bit 3
        #2;
        reset = 1'b0;
        #1;
        cmp++;
        if ({ser_o, frame_o, busy_o, byte_cnt_o} !== {3'b100, 16'h0}) begin
            err++; $display("FAIL rst_async: got ser/frame/busy=%b cnt=%h want 100 0000", {ser_o, frame_o, busy_o}, byte_cnt_o);
        end
        void'(exp_q.pop_front());
        exp_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        recv_frame(wv, fr, dn, waited, idle_ok, extra, to);
        cmp++;
        if (to) begin err++; $display("FAIL rst_resume_timeout: no pop"); return; end
        w = exp_q.pop_front();
        exp_cnt++;
        cmp++;
        if (wv !== build_wave(w)) begin err++; $display("FAIL rst_resume_wave: got %h want %h", wv, build_wave(w)); end
        cmp++;
        if (byte_cnt_o !== exp_cnt) begin err++; $display("FAIL rst_resume_cnt: got %h want %h", byte_cnt_o, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
